// File: rtl/carry_select_adder_32_pkg.sv
// Purpose: shared sizing constants for the 32-bit carry-select adder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package carry_select_adder_32_pkg;

  // Default operand width and select-block width
  localparam int WIDTH = 32;
  localparam int BLOCK = 4;

  // Number of select blocks; block 0 ripples from the external carry-in
  localparam int NUM_BLOCKS = WIDTH / BLOCK;

endpackage

// File: rtl/carry_select_adder_32_rca_block.sv
// Purpose: BLOCK-bit ripple-carry adder slice used by every select block.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module rca_block
  import carry_select_adder_32_pkg::*;
#(
  parameter int W = BLOCK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // c[i] is the carry into bit i; c[W] leaves the slice
  logic [W:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_fa
      // One full adder per bit
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c[W];

endmodule

// File: rtl/carry_select_adder_32.sv
// Purpose: WIDTH-bit carry-select adder, {Cout,Sum} = A + B + Cin, registered.
// Latency: 1 cycle from input sample edge to Sum/Cout; one add per cycle.
// Backpressure: none; free-running stage, synchronous active-high reset clears outputs.
module carry_select_adder_32
  import carry_select_adder_32_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int BLOCK_P = BLOCK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH_P-1:0] A,
  input  logic [WIDTH_P-1:0] B,
  input  logic               Cin,
  output logic [WIDTH_P-1:0] Sum,
  output logic               Cout
);

  localparam int NB = WIDTH_P / BLOCK_P;

  // Partial-width configurations would leave top bits unadded
  generate
    if ((WIDTH_P % BLOCK_P) != 0) begin : g_bad_cfg
      $error("carry_select_adder_32: WIDTH_P must be a multiple of BLOCK_P");
    end
  endgenerate

  // blk_c[k] is the carry into block k; blk_c[NB] is the final carry out
  logic [NB:0]        blk_c;
  logic [WIDTH_P-1:0] sum_d;
  logic               cout_d;
  logic [WIDTH_P-1:0] sum_q;
  logic               cout_q;

  assign blk_c[0] = Cin;

  genvar k;
  generate
    for (k = 0; k < NB; k++) begin : g_blk
      if (k == 0) begin : g_first
        // Lowest block ripples directly from the external carry-in
        rca_block #(.W(BLOCK_P)) u_rca (
          .a    (A[BLOCK_P-1:0]),
          .b    (B[BLOCK_P-1:0]),
          .cin  (blk_c[0]),
          .sum  (sum_d[BLOCK_P-1:0]),
          .cout (blk_c[1])
        );
      end else begin : g_sel
        logic [BLOCK_P-1:0] sum0;
        logic [BLOCK_P-1:0] sum1;
        logic               c0;
        logic               c1;

        // Speculative result assuming no carry into this block
        rca_block #(.W(BLOCK_P)) u_rca0 (
          .a    (A[k*BLOCK_P +: BLOCK_P]),
          .b    (B[k*BLOCK_P +: BLOCK_P]),
          .cin  (1'b0),
          .sum  (sum0),
          .cout (c0)
        );

        // Speculative result assuming a carry into this block
        rca_block #(.W(BLOCK_P)) u_rca1 (
          .a    (A[k*BLOCK_P +: BLOCK_P]),
          .b    (B[k*BLOCK_P +: BLOCK_P]),
          .cin  (1'b1),
          .sum  (sum1),
          .cout (c1)
        );

        // The real incoming carry picks between the two precomputed results
        assign sum_d[k*BLOCK_P +: BLOCK_P] = blk_c[k] ? sum1 : sum0;
        assign blk_c[k+1]                  = blk_c[k] ? c1   : c0;
      end
    end
  endgenerate

  assign cout_d = blk_c[NB];

  // Output register; reset wins over the add and discards the in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_carry_select_adder_32.sv
// Purpose: self-checking bench for carry_select_adder_32 (vector table + random model).
// Latency: expects results one clock after inputs are sampled.
// Backpressure: none; inputs change every cycle.
module tb_carry_select_adder_32;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] Sum;
  logic        Cout;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t tbl [13];

  carry_select_adder_32 dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Sum  (Sum),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] es, input logic ec);
    checks++;
    if (Sum !== es || Cout !== ec) begin
      errors++;
      $display("FAIL %s: got Sum=%h Cout=%b, want Sum=%h Cout=%b", nm, Sum, Cout, es, ec);
    end
  endtask

  // Drive on the falling edge, let one rising edge sample, then look 1 time unit later
  task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    Cin = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] ref_sum;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rr;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    A   = 32'hDEADBEEF;
    B   = 32'h12345678;
    Cin = 1'b1;

    tbl[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
    tbl[1]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1};
    tbl[2]  = '{32'h00000005, 32'hFFFFFFFD, 1'b0, 32'h00000002, 1'b1};
    tbl[3]  = '{32'h00000007, 32'h00000003, 1'b0, 32'h0000000A, 1'b0};
    tbl[4]  = '{32'hFFFFFFFC, 32'hFFFFFFFA, 1'b0, 32'hFFFFFFF6, 1'b1};
    tbl[5]  = '{32'h0000000C, 32'hFFFFFFF8, 1'b1, 32'h00000005, 1'b1};
    tbl[6]  = '{32'hFFFFFFF1, 32'h00000014, 1'b0, 32'h00000005, 1'b1};
    tbl[7]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    tbl[8]  = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0};
    tbl[9]  = '{32'h0FFFFFFF, 32'h00000001, 1'b0, 32'h10000000, 1'b0};
    tbl[10] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    tbl[11] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    tbl[12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};

    // Two reset cycles with non-zero operands present
    apply(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1);
    check("reset_cycle0", 32'h0, 1'b0);
    apply(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    check("reset_cycle1", 32'h0, 1'b0);

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      apply(1'b0, tbl[i].a, tbl[i].b, tbl[i].cin);
      check($sformatf("vec%0d", i), tbl[i].s, tbl[i].co);
    end

    // Reset mid-stream: a live result is replaced by zeros at the reset edge
    apply(1'b0, 32'h12345678, 32'h87654321, 1'b1);
    check("pre_midreset", 32'h9999999A, 1'b0);
    apply(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    check("midreset", 32'h0, 1'b0);
    apply(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    check("post_midreset", 32'h0, 1'b1);
    apply(1'b0, 32'h00000001, 32'h00000001, 1'b0);
    check("post_midreset2", 32'h2, 1'b0);

    // Back-to-back random traffic with occasional resets, against a 33-bit sum
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 63) == 0);
      // Bias some operands toward long carry chains
      if ($urandom_range(0, 7) == 0) rb = ~ra;
      ref_sum = rr ? 33'd0 : ({1'b0, ra} + {1'b0, rb} + {32'd0, rc});
      apply(rr, ra, rb, rc);
      check($sformatf("rand%0d", n), ref_sum[31:0], ref_sum[32]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
